add_accumulator: RTL
====================

# add_accumulator

Downstream consumer of the 4-bit ripple adder stage. It accepts the adder's 5-bit result ({carry_out, S}) under a valid/ready handshake and accumulates a batch of COUNT results into an ACC_W-bit register. It presents the batch total on a held output handshake and flags arithmetic overflow. It converts the combinational adder into a streaming multi-operand summation path.

## Interface

Parameters:
- ACC_W, 8: accumulator width in bits. Must be 5 or greater.
- COUNT, 4: number of adder results per batch. Must be 2 or greater.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result is valid this cycle.
- in_ready  out  1  block can accept a result this cycle.
- S  in  4  sum bits from the adder.
- carry_out  in  1  carry out of the adder; MSB of the 5-bit operand.
- flush  in  1  close the current batch early. Level-sampled.
- out_valid  out  1  batch total available.
- out_ready  in  1  downstream accepts the total.
- acc_out  out  ACC_W  batch total, modulo 2^ACC_W.
- overflow  out  1  total exceeded 2^ACC_W-1 at some point in this batch.
- sample_cnt  out  $clog2(COUNT+1)  results accepted in the current or held batch.

## Operation

- Operand is {carry_out, S}, zero-extended to ACC_W. Its range is 0..31.
- Accept event: in_valid && in_ready.
- States: ACCUM and HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc + operand (truncated to ACC_W); sample_cnt++.
  - On accept: overflow <= overflow | carry out of the ACC_W-bit add.
  - Go to HOLD when an accept brings sample_cnt to COUNT.
  - Go to HOLD when flush=1 and the batch is non-empty after this cycle (sample_cnt>0, or an accept happens this cycle).
  - flush with an empty batch and no accept is ignored.
  - flush and an accept in the same cycle: the operand is included, then the batch closes.
- HOLD:
  - in_ready=0, out_valid=1.
  - acc_out, overflow and sample_cnt are stable.
  - flush and in_valid are ignored.
  - On out_ready=1: acc, overflow and sample_cnt clear to 0; go to ACCUM.
- acc_out always shows the running accumulator, including in ACCUM. It is meaningful to downstream only while out_valid=1.
- Reset: state=ACCUM; acc_out=0, overflow=0, sample_cnt=0, out_valid=0, in_ready=1.
- Reset has priority over every other input. Reset mid-batch or in HOLD discards the partial or held total; no output is produced.

## Timing

- All outputs are registered except in_ready, which is decoded from the state register only (never from out_ready).
- Latency: out_valid rises in the cycle after the accept that completes the batch (or after flush closes it).
- Throughput: one operand per cycle in ACCUM. Each batch costs COUNT accept cycles plus at least 1 HOLD cycle. With out_ready tied high, one batch completes every COUNT+1 cycles.
- The cycle after an out_ready handshake, in_ready=1. There is no same-cycle pass-through from HOLD to an accept.
- Handshake rules:
  - in_valid may be asserted while in_ready=0. The block ignores the operand; upstream holds it.
  - out_valid, once high, stays high until out_ready is sampled high.
- Wrap-around: acc_out wraps modulo 2^ACC_W. overflow is sticky for the batch and clears only on output handshake or reset.
- sample_cnt saturates at COUNT; it never wraps.

## Test plan

- Basic batch (defaults, out_ready=1): operands 5, 7, 31, 1 on consecutive cycles. Expect out_valid=1 one cycle after the 4th accept, acc_out=44, sample_cnt=4, overflow=0. One cycle later out_valid=0 and in_ready=1.
- Overflow (ACC_W=6): operands 31, 31, 31, 1. Expect acc_out=30, overflow=1. A following batch of 1, 1, 1, 1 gives acc_out=4 and overflow=0.
- Backpressure, out_ready=0 for 5 cycles after batch completion:
  - out_valid and acc_out are held for all 5 cycles.
  - in_ready=0 throughout.
  - in_valid pulses during HOLD are not accepted; the next total excludes them.
- Flush, first case: accept 9 and 3, then flush alone. Expect acc_out=12, sample_cnt=2.
- Flush, second case: flush together with an accept of 6 on an empty batch. Expect acc_out=6, sample_cnt=1.
- Flush, third case: flush with an empty batch. Expect no state change.
- Reset mid-operation:
  - Accept 10 and 20, then assert rst for 1 cycle. Expect all outputs at reset values the next cycle.
  - A subsequent batch of 2, 2, 2, 2 yields acc_out=8.
- Reset while in HOLD with out_ready=0: out_valid drops the next cycle. No handshake occurs; in_ready=1.

Source files
------------

// File: rtl/add_accumulator.sv
// Streaming accumulator for 5-bit adder results: sums a batch of COUNT operands,
// holds the total under a valid/ready handshake and flags overflow in the batch.
module add_accumulator #(
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 S,
    input  logic                       carry_out,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           acc_out,
    output logic                       overflow,
    output logic [$clog2(COUNT+1)-1:0] sample_cnt
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic               ovf_reg, ovf_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               out_valid_reg, out_valid_next;

    logic               accept;
    logic [ACC_W-1:0]   operand;
    logic [ACC_W:0]     sum;

    assign in_ready = (state_reg == ACCUM);
    assign accept   = in_valid && in_ready;
    assign operand  = ACC_W'({carry_out, S});
    // One extra bit captures the carry out of the ACC_W-bit add for overflow.
    assign sum      = {1'b0, acc_reg} + {1'b0, operand};

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ACCUM: begin
                if (accept) begin
                    acc_next = sum[ACC_W-1:0];
                    ovf_next = ovf_reg | sum[ACC_W];
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                // Flush closes the batch only if it ends up non-empty this cycle.
                if ((accept && (cnt_reg == CNT_MAX - CNT_W'(1))) ||
                    (flush && ((cnt_reg != '0) || accept))) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
        out_valid_next = (state_next == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            ovf_reg       <= 1'b0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            ovf_reg       <= ovf_next;
            cnt_reg       <= cnt_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign acc_out    = acc_reg;
    assign overflow   = ovf_reg;
    assign sample_cnt = cnt_reg;
    assign out_valid  = out_valid_reg;

endmodule
